wb_stg: RTL

- Write-back stage of the 8-bit pipelined CPU, directly downstream of the data-memory stage.
- Holds the DM/WB pipeline register and selects the write-back value: ALU result, load data or immediate.
- Owns the 4x8 architectural register file and provides two bypassed read ports to decode.
- Drives forwarding data to execute and keeps a retired-instruction counter.

---
 rtl/wb_stg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_stg.sv
// Write-back stage: DM/WB pipeline register, write-back select, 2**RA_W x DW register file.
// Latency: input captured at edge N is bypassed/forwarded in cycle N+1, committed at edge N+1.
// Backpressure: stall holds the stage and suppresses the commit; flush clears the stage and wins over stall.
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   in_valid, opcode_in, rd_in instruction presented by the data-memory stage
//   alu_in, load_in, imm_in    candidate write-back values, chosen by opcode class
//   stall, flush               stage hold / kill of the instruction being captured
//   rs_a, rs_b                 decode read addresses
//   rd_data_a, rd_data_b       bypassed read data for decode
//   fwd_valid, fwd_rd, fwd_data pending write, forwarded to execute
//   wb_en, wb_rd, wb_data      register-file write happening at the next edge
//   retired_count              committed-instruction counter (wraps)
module wb_stg #(
    parameter int DW    = 8,
    parameter int RA_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       opcode_in,
    input  logic [RA_W-1:0]  rd_in,
    input  logic [DW-1:0]    alu_in,
    input  logic [DW-1:0]    load_in,
    input  logic [DW-1:0]    imm_in,
    input  logic             stall,
    input  logic             flush,
    input  logic [RA_W-1:0]  rs_a,
    input  logic [RA_W-1:0]  rs_b,
    output logic [DW-1:0]    rd_data_a,
    output logic [DW-1:0]    rd_data_b,
    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [DW-1:0]    fwd_data,
    output logic             wb_en,
    output logic [RA_W-1:0]  wb_rd,
    output logic [DW-1:0]    wb_data,
    output logic [CNT_W-1:0] retired_count
);

    localparam int NREG = 1 << RA_W;

    localparam logic [3:0] OP_LOAD  = 4'b1101;
    localparam logic [3:0] OP_STORE = 4'b1110;
    localparam logic [3:0] OP_LDI   = 4'b1111;

    // Stage register
    logic            r_s_valid;
    logic [3:0]      r_s_op;
    logic [RA_W-1:0] r_s_rd;
    logic [DW-1:0]   r_s_data;

    // Architectural state
    logic [DW-1:0]    r_regs [NREG];
    logic [CNT_W-1:0] r_retired;

    logic [DW-1:0] w_sel_data;
    logic          w_s_wr;
    logic          w_commit;
    logic          w_wb_en;

    // Write-back value chosen from the incoming opcode class. STORE never
    // writes, so its captured data is a don't-care; it falls into the ALU arm.
    always_comb begin
        w_sel_data = alu_in;
        case (opcode_in)
            OP_LOAD: w_sel_data = load_in;
            OP_LDI:  w_sel_data = imm_in;
            default: w_sel_data = alu_in;
        endcase
    end

    // Stage register. Flush is checked first so that stall+flush discards
    // the held instruction instead of keeping it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_valid <= 1'b0;
            r_s_op    <= '0;
            r_s_rd    <= '0;
            r_s_data  <= '0;
        end else if (flush) begin
            r_s_valid <= 1'b0;
        end else if (!stall) begin
            r_s_valid <= in_valid;
            r_s_op    <= opcode_in;
            r_s_rd    <= rd_in;
            r_s_data  <= w_sel_data;
        end
    end

    // Pending register write held by the stage (independent of stall, so
    // forwarding and bypass stay visible for the whole stall).
    assign w_s_wr   = r_s_valid && (r_s_op != OP_STORE);

    // Commit happens only on the edge that releases the instruction, which
    // makes a stalled instruction write and retire exactly once.
    assign w_commit = r_s_valid && !stall;
    assign w_wb_en  = w_s_wr && !stall;

    // Register file: plain storage, R0 included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[r_s_rd] <= r_s_data;
        end
    end

    // Retired-instruction counter, STORE included; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_commit) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    // Read ports: the pending write overrides the file so decode never sees
    // a stale value during the one cycle before commit (or during a stall).
    assign rd_data_a = (w_s_wr && (r_s_rd == rs_a)) ? r_s_data : r_regs[rs_a];
    assign rd_data_b = (w_s_wr && (r_s_rd == rs_b)) ? r_s_data : r_regs[rs_b];

    assign fwd_valid = w_s_wr;
    assign fwd_rd    = r_s_rd;
    assign fwd_data  = r_s_data;

    assign wb_en   = w_wb_en;
    assign wb_rd   = r_s_rd;
    assign wb_data = r_s_data;

    assign retired_count = r_retired;

endmodule
